// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, default bit timing, data width.
package uart_pkg;

    localparam int unsigned CLK_PER_BIT_DEF = 868;
    localparam int unsigned DATA_W          = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_rx_top_if.sv
// Core-side pop/status port of the buffered UART receiver.
interface uart_rx_top_if;
    import uart_pkg::*;

    logic              rd_req;
    logic              err_clr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rx_empty;
    logic              overrun;
    logic [1:0]        rx_err;

    modport master (
        output rd_req, err_clr,
        input  rd_data, rd_valid, rx_empty, overrun, rx_err
    );

    modport slave (
        input  rd_req, err_clr,
        output rd_data, rd_valid, rx_empty, overrun, rx_err
    );
endinterface

// File: rtl/uart_rx.sv
// UART deserialiser: 2-FF synchronizer, bit timing, FSM and shift register.
// UART_RX_PARITY_EN selects 8E1 framing; otherwise 8N1.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rxd,
    output logic              byte_valid,
    output logic [DATA_W-1:0] byte_data,
    output logic              frame_err,
    output logic              parity_err
);

    localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_PER_BIT - 1);

    rx_state_t         state, state_nx;
    logic              rxd_m, rxd_s, rxd_q;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              at_half, at_full, sample, fall;
`ifdef UART_RX_PARITY_EN
    logic              par_bad;
`endif

    // rxd_q is only for edge detection; rxd_s is the timing reference
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_q <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            rxd_q <= rxd_s;
        end
    end

    assign fall    = rxd_q & ~rxd_s;
    assign at_half = (cnt == HALF_M1);
    assign at_full = (cnt == FULL_M1);
    assign sample  = (state == ST_START) ? at_half : at_full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:      if (fall) state_nx = ST_START;
            ST_START:     if (at_half) state_nx = rxd_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
            ST_DATA:      if (at_full && bit_idx == 3'd7) state_nx = ST_PARITY;
            ST_PARITY:    if (at_full) state_nx = ST_STOP;
`else
            ST_DATA:      if (at_full && bit_idx == 3'd7) state_nx = ST_STOP;
`endif
            ST_STOP:      if (at_full) state_nx = rxd_s ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (rxd_s) state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        parity_err = 1'b0;
        case (state)
`ifdef UART_RX_PARITY_EN
            ST_PARITY: parity_err = at_full & (rxd_s ^ (^shreg));
            ST_STOP: begin
                byte_valid = at_full & rxd_s & ~par_bad;
                frame_err  = at_full & ~rxd_s;
            end
`else
            ST_STOP: begin
                byte_valid = at_full & rxd_s;
                frame_err  = at_full & ~rxd_s;
            end
`endif
            default: ;
        endcase
    end

    // Counter restarts on every state change and after each sample point
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state != state_nx || state == ST_IDLE || state == ST_WAIT_HIGH || sample)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (state == ST_START)
                bit_idx <= '0;
            else if (state == ST_DATA && at_full)
                bit_idx <= bit_idx + 1'b1;

            if (state == ST_DATA && at_full)
                shreg <= {rxd_s, shreg[DATA_W-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                  par_bad <= 1'b0;
        else if (state == ST_START) par_bad <= 1'b0;
        else if (parity_err)        par_bad <= 1'b1;
    end
`endif

    assign byte_data = shreg;

endmodule

// File: rtl/uart_rx_top.sv
// Buffered UART receiver: ring-buffer RAM, pointers, sticky error flags, core pop port.
// UART_RX_PARITY_EN enables 8E1 framing and the rx_err[1] parity flag.
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEF,
    parameter int unsigned ADDR_W      = 12
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rxd,
    uart_rx_top_if.slave  core
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic              byte_valid, frame_err, parity_err;
    logic [DATA_W-1:0] byte_data;
    logic              wr_pend;
    logic [DATA_W-1:0] wr_byte;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wp, rp, wp_inc;
    logic              empty, full, do_wr, do_rd;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, overrun, err_frm, err_par;

    uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
        .clk        (clk),
        .rstn       (rstn),
        .rxd        (rxd),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    // Received byte is staged one cycle before the buffer write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_pend <= 1'b0;
            wr_byte <= '0;
        end else begin
            wr_pend <= byte_valid;
            if (byte_valid) wr_byte <= byte_data;
        end
    end

    assign wp_inc = wp + ADDR_W'(1);
    assign empty  = (wp == rp);
    assign full   = (wp_inc == rp);
    assign do_wr  = wr_pend & ~full;
    assign do_rd  = core.rd_req & ~empty;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= wr_byte;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp       <= '0;
            rp       <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (do_wr) wp <= wp_inc;
            if (do_rd) begin
                rp      <= rp + ADDR_W'(1);
                rd_data <= mem[rp];
            end
            rd_valid <= do_rd;
        end
    end

    // A new error event outranks a same-cycle clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun <= 1'b0;
            err_frm <= 1'b0;
        end else begin
            overrun <= (wr_pend & full) | (overrun & ~core.err_clr);
            err_frm <= frame_err | (err_frm & ~core.err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err_par <= 1'b0;
        else       err_par <= parity_err | (err_par & ~core.err_clr);
    end
`else
    assign err_par = parity_err;
`endif

    assign core.rd_data  = rd_data;
    assign core.rd_valid = rd_valid;
    assign core.rx_empty = empty;
    assign core.overrun  = overrun;
    assign core.rx_err   = {err_par, err_frm};

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: directed scenarios plus random traffic vs. a queue model.
module tb_uart_rx_top;

    localparam int unsigned CPB = 16;
    localparam int unsigned AW  = 3;
    localparam int unsigned CAP = (1 << AW) - 1;

    logic clk = 1'b0;
    logic rstn;
    logic rxd;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [7:0] q[$];
    logic       m_ovr;
    logic       m_ferr;
    logic [7:0] m_last;

    uart_rx_top_if bus ();

    uart_rx_top #(.CLK_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .rxd  (rxd),
        .core (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one frame at the pin, then apply its effect to the model.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rxd = ^b;
        repeat (CPB) @(negedge clk);
`endif
        rxd = stop_ok;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        if (!stop_ok) repeat (CPB) @(negedge clk);
        if (!stop_ok)               m_ferr = 1'b1;
        else if (q.size() < CAP)    q.push_back(b);
        else                        m_ovr = 1'b1;
    endtask

    task automatic check_flags(input string tag);
        check_eq({tag, ".rx_empty"}, bus.rx_empty, q.size() == 0);
        check_eq({tag, ".overrun"},  bus.overrun,  m_ovr);
        check_eq({tag, ".rx_err"},   bus.rx_err,   {1'b0, m_ferr});
        check_eq({tag, ".rd_valid"}, bus.rd_valid, 1'b0);
    endtask

    // n back-to-back pop requests, each result checked the following cycle.
    task automatic pop_burst(input int n);
        logic exp_v;
        exp_v = 1'b0;
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                check_eq("pop.rd_valid", bus.rd_valid, exp_v);
                check_eq("pop.rd_data",  bus.rd_data,  m_last);
                check_eq("pop.rx_empty", bus.rx_empty, q.size() == 0);
            end
            if (i < n) begin
                bus.rd_req = 1'b1;
                if (q.size() > 0) begin
                    exp_v  = 1'b1;
                    m_last = q.pop_front();
                end else begin
                    exp_v = 1'b0;
                end
                @(negedge clk);
            end else begin
                bus.rd_req = 1'b0;
            end
        end
    endtask

    task automatic pulse_err_clr();
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".rd_data"},  bus.rd_data,  8'h00);
        check_eq({tag, ".rd_valid"}, bus.rd_valid, 1'b0);
        check_eq({tag, ".rx_empty"}, bus.rx_empty, 1'b1);
        check_eq({tag, ".overrun"},  bus.overrun,  1'b0);
        check_eq({tag, ".rx_err"},   bus.rx_err,   2'b00);
    endtask

    initial begin
        rstn        = 1'b0;
        rxd         = 1'b1;
        bus.rd_req  = 1'b0;
        bus.err_clr = 1'b0;
        m_ovr       = 1'b0;
        m_ferr      = 1'b0;
        m_last      = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Single byte with exact arrival latency (pin low at cycle C, rxd_s falls C+2)
        fork
            send_byte(8'hA5, 1'b1);
            begin
                repeat (155) @(negedge clk);
                check_eq("lat.before", bus.rx_empty, 1'b1);
                @(negedge clk);
                check_eq("lat.at", bus.rx_empty, 1'b0);
            end
        join
        check_flags("a5");
        pop_burst(1);

        // Back-to-back frames, consecutive pops
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3C, 1'b1);
        check_flags("b2b");
        pop_burst(3);

        // Fill past capacity
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), 1'b1);
            check_flags("fill");
        end
        pop_burst(8);
        pulse_err_clr();
        check_flags("ovr_clr");

        // Framing error, then clear
        send_byte(8'h55, 1'b0);
        check_flags("ferr");
        pulse_err_clr();
        check_flags("ferr_clr");

        // Short low glitch must not start a frame
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_flags("glitch");

        // Pop while empty, then reset in the middle of a frame
        pop_burst(2);
        send_byte(8'h11, 1'b1);
        rxd = 1'b0;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            check_eq("mid.rd_valid", bus.rd_valid, 1'b0);
        end
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst.rd_valid", bus.rd_valid, 1'b0);
        end
        rxd  = 1'b1;
        rstn = 1'b1;
        q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        m_last = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("post.rd_valid", bus.rd_valid, 1'b0);
        end
        check_reset_state("midrst");
        send_byte(8'h7E, 1'b1);
        check_flags("7e");
        pop_burst(1);

        // Random traffic against the queue model
        for (int n = 0; n < 30; n++) begin
            int unsigned op;
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 9) != 0));
            end else if (op <= 7) begin
                pop_burst(int'($urandom_range(1, 3)));
                @(negedge clk);
            end else if (op == 8) begin
                pulse_err_clr();
            end else begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
            end
            check_flags("rand");
        end
        pop_burst(CAP + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_top.md
# uart_rx_top

Core-side buffered UART receiver, the receive counterpart of the buffered transmit path. It deserialises 8N1 frames from the `rxd` pin and stores each good byte in a power-of-two ring buffer. The processor core pops bytes one per request. Bytes that arrive while the core is busy are held until read; bytes that arrive while the buffer is full are dropped and flagged.

## Interface
Parameters:
- `CLK_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 8.
- `ADDR_W`, default 12: ring-buffer address width. Depth is 2^ADDR_W; usable capacity is 2^ADDR_W − 1.

Ports:
- `clk`  in  1: single clock.
- `rstn`  in  1: reset, asynchronous and active-low.
- `rxd`  in  1: serial input, asynchronous to `clk`, idles high.
- `rd_req`  in  1: one-cycle pop request from the core.
- `err_clr`  in  1: clears `overrun` and `rx_err`.
- `rd_data`  out  8: popped byte. Valid only while `rd_valid` = 1.
- `rd_valid`  out  1: one-cycle pulse, asserted the cycle after an accepted `rd_req`.
- `rx_empty`  out  1: 1 when the buffer holds no bytes.
- `overrun`  out  1: sticky. Set when a good byte is dropped because the buffer is full.
- `rx_err`  out  2: sticky. Bit 0 = framing error, bit 1 = parity error.

## Operation
- `rxd` passes through a 2-FF synchronizer, giving `rxd_s`. All timing below is relative to `rxd_s`.
- The receiver FSM (`uart_rx`) has states IDLE, START, DATA, STOP, WAIT_HIGH. A bit counter counts 0..CLK_PER_BIT−1.
  - IDLE → START on a `rxd_s` falling edge.
  - START: at CLK_PER_BIT/2 (integer division), sample `rxd_s`. If 1, treat as a glitch and go to IDLE. If 0, go to DATA.
  - DATA: sample 8 bits, LSB first, each a full CLK_PER_BIT after the previous sample.
  - STOP: sample the stop bit. If 1, pulse `byte_valid` for one cycle and go to IDLE. If 0, set `rx_err[0]`, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH → IDLE once `rxd_s` = 1.
- The buffer uses write pointer `wp` and read pointer `rp`, each ADDR_W bits, wrapping naturally.
  - Empty when `wp == rp`. Full when `wp + 1 == rp`.
- On a `byte_valid` pulse:
  - If not full: write the byte at `wp`, then increment `wp`.
  - If full: drop the byte and set `overrun`.
- `rd_req` with `rx_empty` = 0: read the byte at `rp`, increment `rp`, and drive `rd_data` / `rd_valid` the next cycle.
- `rd_req` with `rx_empty` = 1: ignored. `rd_valid` stays 0 and `rd_data` holds its value.
- Simultaneous write and pop: both proceed. The full and empty checks use pre-update pointers.
- `err_clr` and a new error event in the same cycle: the error wins (the bit remains set).
- Reset mid-frame: FSM returns to IDLE, pointers go to 0, and buffered data is lost.

## Timing
- Reset values:
  - `rd_data` = 0, `rd_valid` = 0, `rx_empty` = 1, `overrun` = 0, `rx_err` = 0.
  - FSM in IDLE; `wp` = `rp` = 0.
- Stop-bit sample happens at T0 + CLK_PER_BIT/2 + 9·CLK_PER_BIT, where T0 is the cycle of the `rxd_s` falling edge. `byte_valid` pulses that cycle.
- The buffer write occurs in the cycle after `byte_valid`. `rx_empty` falls one cycle after the write.
- Pop latency: `rd_req` in cycle N gives `rd_valid` in N+1. `rx_empty` reflects the new `rp` in N+1.
- Minimum core-side spacing: one `rd_req` per cycle.
- The buffer RAM uses synchronous read, so it infers as block RAM.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1. FSM state PARITY sits between DATA and STOP.
  - A parity mismatch sets `rx_err[1]`. The byte is then dropped even if the stop bit is good.
  - Stop-bit sample moves to T0 + CLK_PER_BIT/2 + 10·CLK_PER_BIT.
- Undefined: frame is 8N1, there is no PARITY state, and `rx_err[1]` is tied to 0.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH).
  - Default `CLK_PER_BIT`.
  - Data width constant 8.
- Sub-module `uart_rx`: synchronizer, bit-timing counter, FSM and shift register. Outputs `byte_valid`, `byte_data`, `frame_err`, `parity_err`.
- `uart_rx_top` holds the RAM, pointers, sticky flags and core read port.

## Test plan
Bench settings: CLK_PER_BIT = 16, ADDR_W = 3 (capacity 7).
- Send 0xA5, then pulse `rd_req` → `rx_empty` falls at T0 + 154 cycles; `rd_valid` = 1 with `rd_data` = 0xA5 one cycle after `rd_req`; `rx_empty` = 1 again.
- Send 0x00, 0xFF, 0x3C back-to-back, then 3 pops on consecutive cycles → `rd_data` = 0x00, 0xFF, 0x3C on 3 consecutive `rd_valid` pulses.
- Send 0x01..0x08 with no reads → `overrun` = 1 after the 8th byte; 7 pops return 0x01..0x07; the 8th `rd_req` gives no `rd_valid`.
- Send 0x55 with the stop bit forced 0 → `rx_err` = 2'b01, `rx_empty` stays 1. Then pulse `err_clr` → `rx_err` = 0.
- Drive `rxd` low for 4 cycles, then high → no byte stored, no error.
- Pulse `rd_req` while empty, and assert `rstn` = 0 mid-frame → `rd_valid` never pulses. After reset, all outputs are at reset values, and a following 0x7E is received correctly.
